// File: rtl/serial_adder_sub_if.sv
// rtl/serial_adder_sub_if.sv - start/done handshake and operand/result bundle for serial_adder_sub
interface serial_adder_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_sub.sv
// rtl/serial_adder_sub.sv - digit-serial add/subtract, DIGIT bits per cycle, LSB first
module serial_adder_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_sub_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_adder_sub: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] s_d;
  logic             c_d;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] r_next;

  assign a_d = a_sh[DIGIT-1:0];
  assign b_d = b_sh[DIGIT-1:0];
  assign {c_d, s_d} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};

  // Carry into the digit MSB recovered from its sum bit, so overflow needs no extra adder.
  assign msb_cin = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ s_d[DIGIT-1];
  assign last    = (cnt == CW'(N - 1));

  if (DIGIT == WIDTH) begin : g_single
    assign r_next = s_d;
  end else begin : g_multi
    assign r_next = {s_d, r_sh[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b ^ {WIDTH{bus.sub}};
            carry  <= bus.cin ^ bus.sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          r_sh  <= r_next;
          carry <= c_d;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= r_next;
            cout_q <= c_d;
            ovf_q  <= msb_cin ^ c_d;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// tb/tb_serial_adder_sub.sv - directed checks of serial_adder_sub for DIGIT = 1, 4 and 8
module tb_serial_adder_sub;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_adder_sub_if #(.WIDTH(8)) m1 ();
  serial_adder_sub_if #(.WIDTH(8)) m4 ();
  serial_adder_sub_if #(.WIDTH(8)) m8 ();

  serial_adder_sub #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(m1.slave));
  serial_adder_sub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(m4.slave));
  serial_adder_sub #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(m8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one DIGIT=1 operation; optionally pokes start and scrambles operands mid-run
  // while checking the previous result is still held.
  task automatic op1(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic poke, input logic [7:0] held,
                     output int lat, output int busy_cnt);
    @(negedge clk);
    m1.start = 1'b1; m1.sub = s; m1.a = a; m1.b = b; m1.cin = c;
    @(negedge clk);
    m1.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!m1.done && lat < 50) begin
      if (m1.busy) busy_cnt++;
      if (poke && lat == 3) begin
        check({tag, "_held_sum"}, 32'(m1.sum), 32'(held));
        m1.start = 1'b1; m1.sub = ~s; m1.a = ~a; m1.b = 8'h5A; m1.cin = ~c;
      end
      lat++;
      @(negedge clk);
    end
    m1.start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd8);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    total = 0;
    bad = 0;
    rst = 1'b1;
    m1.start = 0; m1.sub = 0; m1.a = 0; m1.b = 0; m1.cin = 0;
    m4.start = 0; m4.sub = 0; m4.a = 0; m4.b = 0; m4.cin = 0;
    m8.start = 0; m8.sub = 0; m8.a = 0; m8.b = 0; m8.cin = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(m1.busy), 32'd0);
    check("rst_done", 32'(m1.done), 32'd0);
    check("rst_outs", {23'd0, m1.cout, m1.overflow, m1.sum}, 32'd0);
    rst = 1'b0;

    op1("add5a3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, lat, bc);
    check("add5a3c_busy_cycles", 32'(bc), 32'd8);
    check("add5a3c_sum", 32'(m1.sum), 32'h96);
    check("add5a3c_cout_ovf", {30'd0, m1.cout, m1.overflow}, 32'b01);
    check("add5a3c_busy_in_done", 32'(m1.busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(m1.done), 32'd0);
    check("hold_in_idle", 32'(m1.sum), 32'h96);

    op1("addff01", 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, lat, bc);
    check("addff01_sum", 32'(m1.sum), 32'h00);
    check("addff01_cout_ovf", {30'd0, m1.cout, m1.overflow}, 32'b10);

    op1("sub1020", 1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 8'h00, lat, bc);
    check("sub1020_sum", 32'(m1.sum), 32'hF0);
    check("sub1020_cout_ovf", {30'd0, m1.cout, m1.overflow}, 32'b00);

    op1("sub8001", 1'b1, 8'h80, 8'h01, 1'b0, 1'b0, 8'h00, lat, bc);
    check("sub8001_sum", 32'(m1.sum), 32'h7F);
    check("sub8001_cout_ovf", {30'd0, m1.cout, m1.overflow}, 32'b11);

    // Reset three cycles into a run: outputs clear at once and no done follows.
    @(negedge clk);
    m1.start = 1'b1; m1.sub = 1'b0; m1.a = 8'h12; m1.b = 8'h34; m1.cin = 1'b0;
    @(negedge clk);
    m1.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(m1.busy), 32'd0);
    check("abort_outs", {23'd0, m1.cout, m1.overflow, m1.sum}, 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (m1.done) seen++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (m1.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    op1("add1234", 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, lat, bc);
    check("add1234_sum", 32'(m1.sum), 32'h46);
    check("add1234_cout_ovf", {30'd0, m1.cout, m1.overflow}, 32'b00);

    // DIGIT=4: two digits per operation.
    @(negedge clk);
    m4.start = 1'b1; m4.sub = 1'b0; m4.a = 8'hA7; m4.b = 8'h59; m4.cin = 1'b1;
    @(negedge clk);
    m4.start = 1'b0;
    lat = 0;
    while (!m4.done && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("d4_latency", 32'(lat), 32'd2);
    check("d4_sum", 32'(m4.sum), 32'h01);
    check("d4_cout_ovf", {30'd0, m4.cout, m4.overflow}, 32'b10);

    // DIGIT=8 with start held: done every third cycle.
    @(negedge clk);
    m8.start = 1'b1; m8.sub = 1'b0; m8.a = 8'h01; m8.b = 8'h01; m8.cin = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("d8_done_%0d", i), 32'(m8.done), 32'((i % 3) == 1));
      if (m8.done)
        check($sformatf("d8_result_%0d", i), {22'd0, m8.cout, m8.overflow, m8.sum}, 32'h002);
    end
    m8.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
- Parametrised, digit-serial successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands, processing DIGIT bits per clock, LSB first, with a registered inter-digit carry.
- Uses a start/done handshake; results are registered and held until the next operation completes.
- Used wherever area matters more than latency (datapath labs, ALU back-ends).

Parameters:
- WIDTH, 8, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 1, bits processed per RUN cycle; 1 = bit-serial, WIDTH = single-cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  mode, sampled with start: 0 = add, 1 = subtract.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in (add) or borrow-in (subtract), sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum, cout and overflow are valid.
- sum  output  WIDTH  result.
- cout  output  1  final carry out (in subtract mode, 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - busy, done, cout, overflow = 0; sum = 0.
  - Internal shift registers, carry and digit counter = 0.
  - Takes effect immediately, including mid-operation; an aborted operation never produces done.
- Arithmetic:
  - Add: sum = a + b + cin.
  - Subtract: sum = a + ~b + ~cin, i.e. a − b − cin.
  - Initial carry = cin XOR sub; B is inverted when sub=1.
  - cout = carry out of bit WIDTH−1.
  - overflow = carry into MSB XOR carry out of MSB.
- FSM, states IDLE, RUN, DONE; N = WIDTH/DIGIT:
  - IDLE: on a clock edge with start=1, latch a, b^{WIDTH{sub}} and the initial carry; counter = 0; go to RUN. start=0 → stay in IDLE.
  - RUN: busy=1. Each edge adds the low DIGIT bits of the A/B shift registers plus the carry, shifts them right by DIGIT, shifts the partial result in from the MSB side, updates the carry and increments the counter. On the edge that processes digit N−1: load the sum/cout/overflow output registers and go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle; next edge → IDLE unconditionally.
- Timing:
  - done is high in the cycle beginning N edges after the edge that sampled start.
  - A new start can be accepted at the earliest in the IDLE cycle following DONE.
  - Throughput: one operation per N+2 cycles.
- Output holding:
  - sum, cout and overflow change only on entry to DONE (and on reset).
  - They hold their values through IDLE and through the whole of the next RUN.
- Boundary conditions:
  - start high in RUN or DONE: ignored, not queued.
  - a, b, sub and cin changing during RUN: no effect.
  - start held high continuously: a new operation starts at every IDLE cycle.
  - DIGIT = WIDTH: N = 1, done arrives 1 cycle after start.
  - Carry wraps between digits only; no carry enters the next operation.
- Out-of-range parameters: WIDTH % DIGIT ≠ 0 is illegal; the RTL flags it with an elaboration-time check.

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A, b=0x3C, cin=0 → after 8 cycles done=1, sum=0x96, cout=0, overflow=1; busy high for exactly 8 cycles.
- Add a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0; then start=1 during the following RUN is ignored and the prior result stays held until the next done.
- Subtract a=0x10, b=0x20, cin=0 → sum=0xF0, cout=0 (borrow), overflow=0. Subtract a=0x80, b=0x01, cin=0 → sum=0x7F, cout=1, overflow=1.
- Reset mid-operation: start a=0x12, b=0x34, assert rst after 3 RUN cycles → outputs immediately 0, state IDLE, no done pulse; after release, a=0x12+0x34 → sum=0x46.
- WIDTH=8, DIGIT=4, add a=0xA7, b=0x59, cin=1 → done 2 cycles after start, sum=0x01, cout=1, overflow=0.
- WIDTH=8, DIGIT=8, start held high with a=0x01, b=0x01, cin=0 → done every 3rd cycle with sum=0x02, cout=0, overflow=0.
